// File: rtl/fsm_seq_driver_if.sv
// Stimulus/response bundle between a sequence player and its controller.
// Latency: none (wires only).
// Backpressure: none; start and load_en are single-cycle strobes.
//
// Ports (signals in the bundle):
//   load_en, load_addr, load_data : vector memory write port
//   seq_len, start                : playback request
//   a, b                          : stimulus to the FSM under test
//   y0, y1                        : responses of the FSM under test
//   busy, done, pass              : run status
//   err_count, first_err_idx      : run result
//
// slave modport is the player; master modport is whoever controls it
// and also hosts the FSM under test.
interface fsm_seq_driver_if #(
    parameter int AW = 3
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [3:0]    load_data;
    logic [AW:0]   seq_len;
    logic          start;
    logic          a;
    logic          b;
    logic          y0;
    logic          y1;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_idx;

    modport master (
        output load_en, load_addr, load_data, seq_len, start, y0, y1,
        input  a, b, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        input  load_en, load_addr, load_data, seq_len, start, y0, y1,
        output a, b, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/fsm_seq_driver.sv
// Plays stored {a,b,exp_y0,exp_y1} vectors into an FSM and checks its outputs.
// Latency: start -> first a/b 1 cycle; start -> done len+3 cycles; check 2 cycles after drive.
// Backpressure: none; start/load_en while busy are ignored.
//
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : fsm_seq_driver_if.slave (load port, start/seq_len, a/b out,
//              y0/y1 in, busy/done/pass/err_count/first_err_idx out)
// Build option: define FSM_SEQ_STOP_ON_ERR_EN to abort a run on its first mismatch.
module fsm_seq_driver #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    fsm_seq_driver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    logic [3:0]    mem [DEPTH];

    state_t        state_q;
    state_t        state_d;

    logic [AW:0]   len_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic [AW-1:0] idx_inc;
    logic          drain_q;

    logic          a_q;
    logic          b_q;
    logic          pass_q;
    logic [AW:0]   err_q;
    logic [AW-1:0] first_q;

    // expected-value pipeline: stage 1 matches the a/b register, stage 2
    // lines up with the FSM-under-test response one cycle later
    logic          s1_vld;
    logic [1:0]    s1_exp;
    logic [AW-1:0] s1_idx;
    logic          s2_vld;
    logic [1:0]    s2_exp;
    logic [AW-1:0] s2_idx;

    logic          stim_vld;
    logic [3:0]    stim_vec;
    logic          accept;
    logic [AW:0]   len_clamp;
    logic          last_vec;
    logic          mismatch;
    logic          abort;
    logic [3:0]    first_vec;

    assign accept    = (state_q == IDLE) && bus.start;
    assign len_clamp = (bus.seq_len > DEPTH_W) ? DEPTH_W : bus.seq_len;
    assign last_vec  = ({1'b0, idx_q} == (len_q - ONE_W));
    assign idx_inc   = idx_q + ONE_A;

    // A write to address 0 on the start edge must be seen by vector 0.
    assign first_vec = (bus.load_en && (bus.load_addr == '0)) ? bus.load_data : mem[0];

    assign mismatch = s2_vld && ({bus.y0, bus.y1} != s2_exp) &&
                      ((state_q == RUN) || (state_q == DRAIN));

`ifdef FSM_SEQ_STOP_ON_ERR_EN
    assign abort = mismatch;
`else
    assign abort = 1'b0;
`endif

    // Vector memory: written only while idle, never reset.
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q == IDLE)) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (len_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (last_vec) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // drain_q marks the second DRAIN cycle
                if (abort || drain_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: which vector (if any) goes onto a/b after this edge
    always_comb begin
        stim_vld = 1'b0;
        stim_vec = '0;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (len_clamp != '0)) begin
                    stim_vld = 1'b1;
                    stim_vec = first_vec;
                    idx_d    = '0;
                end
            end
            RUN: begin
                if (!last_vec && !abort) begin
                    stim_vld = 1'b1;
                    stim_vec = mem[idx_inc];
                    idx_d    = idx_inc;
                end
            end
            default: begin
                stim_vld = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            drain_q <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            s1_vld  <= 1'b0;
            s1_exp  <= '0;
            s1_idx  <= '0;
            s2_vld  <= 1'b0;
            s2_exp  <= '0;
            s2_idx  <= '0;
        end else begin
            a_q     <= stim_vld & stim_vec[3];
            b_q     <= stim_vld & stim_vec[2];
            idx_q   <= idx_d;
            drain_q <= (state_q == DRAIN);

            s1_vld  <= stim_vld;
            s1_exp  <= stim_vec[1:0];
            s1_idx  <= idx_d;
            s2_vld  <= s1_vld;
            s2_exp  <= s1_exp;
            s2_idx  <= s1_idx;

            // an aborted run must not keep scoring in-flight vectors
            if (abort) begin
                s1_vld <= 1'b0;
                s2_vld <= 1'b0;
            end

            if (accept) begin
                len_q   <= len_clamp;
                err_q   <= '0;
                first_q <= '0;
            end else if (mismatch) begin
                err_q <= err_q + ONE_W;
                if (err_q == '0) begin
                    first_q <= s2_idx;
                end
            end

            // an empty run passes; otherwise include a mismatch landing on the DONE edge
            if (accept) begin
                pass_q <= (len_clamp == '0);
            end else if (state_d == DONE) begin
                pass_q <= (err_q == '0) && !mismatch;
            end
        end
    end

    assign bus.a             = a_q;
    assign bus.b             = b_q;
    assign bus.busy          = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Bench for fsm_seq_driver: hosts a small Moore FSM as the device under test
// and scoreboards expected stimulus and run results against the player.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fsm_seq_driver;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_seq_driver_if #(.AW(AW)) bus ();

    fsm_seq_driver #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FSM under test: S0=00, S1=01, S2=10 presented on {y0,y1}.
    // ab=00 -> S0, 10 -> S1, 01 -> S2, 11 -> hold.
    function automatic logic [1:0] fut_next(input logic [1:0] s, input logic a, input logic b);
        case ({a, b})
            2'b00:   return 2'b00;
            2'b10:   return 2'b01;
            2'b01:   return 2'b10;
            default: return s;
        endcase
    endfunction

    logic [1:0] fut_q;
    always @(posedge clk) begin
        if (rst) fut_q <= 2'b00;
        else     fut_q <= fut_next(fut_q, bus.a, bus.b);
    end
    assign bus.y0 = fut_q[1];
    assign bus.y1 = fut_q[0];

    typedef struct {
        logic          pass;
        logic [AW:0]   err;
        logic [AW-1:0] first;
        int            lat;
    } res_t;

    logic [3:0] mem_m [DEPTH];
    logic [1:0] ab_q[$];
    res_t       res_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_vec(input int addr, input logic [3:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(addr);
        bus.load_data = d;
        mem_m[addr]   = d;
        tick();
        bus.load_en   = 1'b0;
    endtask

    // Starts a run, scoreboards every a/b cycle and the final result.
    task automatic run_seq(input int len, input bit ign_start, input bit mid_load,
                           input bit ld_start, input int ld_addr, input logic [3:0] ld_data);
        int         eff;
        logic [1:0] st;
        logic [1:0] exp_ab;
        logic       exp_busy;
        res_t       r;
        res_t       got;
        bit         seen;
        int         cyc;

        if (ld_start) mem_m[ld_addr] = ld_data;
        eff     = (len > DEPTH) ? DEPTH : len;
        st      = 2'b00;
        r.err   = '0;
        r.first = '0;
        for (int k = 0; k < eff; k++) begin
            ab_q.push_back(mem_m[k][3:2]);
            st = fut_next(st, mem_m[k][3], mem_m[k][2]);
            if (st != mem_m[k][1:0]) begin
                if (r.err == '0) r.first = AW'(k);
                r.err = r.err + (AW+1)'(1);
            end
        end
        r.pass = (r.err == '0);
        r.lat  = (eff == 0) ? 1 : eff + 3;
        res_q.push_back(r);

        bus.seq_len = (AW+1)'(len);
        bus.start   = 1'b1;
        if (ld_start) begin
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(ld_addr);
            bus.load_data = ld_data;
        end
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;

        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc <= 30) begin
            exp_ab   = (cyc <= eff && ab_q.size() > 0) ? ab_q.pop_front() : 2'b00;
            exp_busy = (eff > 0) && (cyc <= eff + 2);
            n_checks++;
            if ({bus.a, bus.b} !== exp_ab)
                $display("FAIL stim len=%0d cyc=%0d: ab got %b expected %b", len, cyc, {bus.a, bus.b}, exp_ab);
            else n_pass++;
            n_checks++;
            if (bus.busy !== exp_busy)
                $display("FAIL busy len=%0d cyc=%0d: got %b expected %b", len, cyc, bus.busy, exp_busy);
            else n_pass++;

            if (bus.done === 1'b1) begin
                seen = 1'b1;
                got  = res_q.pop_front();
                n_checks++;
                if (cyc != got.lat)
                    $display("FAIL latency len=%0d: done after %0d cycles, expected %0d", len, cyc, got.lat);
                else n_pass++;
                n_checks++;
                if (bus.pass !== got.pass)
                    $display("FAIL pass len=%0d: got %b expected %b", len, bus.pass, got.pass);
                else n_pass++;
                n_checks++;
                if (bus.err_count !== got.err)
                    $display("FAIL err_count len=%0d: got %0d expected %0d", len, bus.err_count, got.err);
                else n_pass++;
                n_checks++;
                if (bus.first_err_idx !== got.first)
                    $display("FAIL first_err_idx len=%0d: got %0d expected %0d", len, bus.first_err_idx, got.first);
                else n_pass++;
            end else begin
                if (ign_start && cyc == 3) bus.start = 1'b1;
                if (mid_load && cyc == 2) begin
                    bus.load_en   = 1'b1;
                    bus.load_addr = AW'(4);
                    bus.load_data = 4'b1111;
                end
                tick();
                bus.start   = 1'b0;
                bus.load_en = 1'b0;
                cyc++;
            end
        end

        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout len=%0d: no done within 30 cycles", len);
            got = res_q.pop_front();
        end else begin
            tick();
            n_checks++;
            if (bus.done !== 1'b0 || bus.pass !== got.pass)
                $display("FAIL hold len=%0d: done=%b pass=%b expected done=0 pass=%b", len, bus.done, bus.pass, got.pass);
            else n_pass++;
        end
        ab_q.delete();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.a, bus.b} !== 2'b00) $display("FAIL reset_ab: got %b expected 00", {bus.a, bus.b}); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
        n_checks++;
        if (bus.pass !== 1'b0) $display("FAIL reset_pass: got %b expected 0", bus.pass); else n_pass++;
        n_checks++;
        if (bus.err_count !== '0) $display("FAIL reset_err: got %0d expected 0", bus.err_count); else n_pass++;
        n_checks++;
        if (bus.first_err_idx !== '0) $display("FAIL reset_first: got %0d expected 0", bus.first_err_idx); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic load_golden();
        load_vec(0, 4'b0000);
        load_vec(1, 4'b1001);
        load_vec(2, 4'b1101);
        load_vec(3, 4'b0000);
        load_vec(4, 4'b0110);
        load_vec(5, 4'b0000);
        load_vec(6, 4'b1001);
        load_vec(7, 4'b0110);
    endtask

    task automatic test_pass_run();
        run_seq(6, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    endtask

    task automatic test_mismatch();
        load_vec(3, 4'b0010);
        run_seq(6, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        load_vec(3, 4'b0000);
    endtask

    task automatic test_zero_len();
        run_seq(0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    endtask

    task automatic test_clamp();
        run_seq(12, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
    endtask

    task automatic test_load_during_run();
        run_seq(6, 1'b0, 1'b1, 1'b0, 0, 4'b0000);
        run_seq(6, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    endtask

    task automatic test_reset_mid_run();
        bus.seq_len = (AW+1)'(6);
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.a, bus.b} !== mem_m[2][3:2])
            $display("FAIL midrun_vec2: got %b expected %b", {bus.a, bus.b}, mem_m[2][3:2]);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL midrun_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++;
        if ({bus.a, bus.b} !== 2'b00) $display("FAIL midrun_ab: got %b expected 00", {bus.a, bus.b}); else n_pass++;
        n_checks++;
        if (bus.err_count !== '0 || bus.done !== 1'b0)
            $display("FAIL midrun_status: err=%0d done=%b expected 0/0", bus.err_count, bus.done);
        else n_pass++;
        tick();
        run_seq(6, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    endtask

    task automatic test_load_same_edge();
        run_seq(3, 1'b0, 1'b0, 1'b1, 0, 4'b1001);
        load_vec(0, 4'b0000);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < DEPTH; k++) load_vec(k, 4'($urandom_range(0, 15)));
            run_seq(int'($urandom_range(0, 10)), 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        end
    endtask

    initial begin
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.seq_len   = '0;
        bus.start     = 1'b0;

        test_reset();
        load_golden();
        test_pass_run();
        test_mismatch();
        test_zero_len();
        test_clamp();
        test_load_during_run();
        test_reset_mid_run();
        test_load_same_edge();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_seq_driver.md
FSM_SEQ_DRIVER -- requirements
Module: fsm_seq_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of stored stimulus vectors.
REQ-002 SHALL have parameter AW, default 3, meaning the vector address width; DEPTH = 2**AW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_en  input  1  write load_data into vector memory at load_addr.
REQ-006 load_addr  input  AW  vector memory write address.
REQ-007 load_data  input  4  vector {a, b, exp_y0, exp_y1}, MSB first.
REQ-008 seq_len  input  AW+1  number of vectors to play, sampled on start.
REQ-009 start  input  1  single-cycle request to begin playback.
REQ-010 a, b  output  1 each  registered stimulus to the FSM under test.
REQ-011 y0, y1  input  1 each  outputs of the FSM under test.
REQ-012 busy  output  1  high from the start-accept edge until the done edge.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 pass  output  1  high when the last run had zero mismatches; held until the next start.
REQ-015 err_count  output  AW+1  mismatch count of the current or last run.
REQ-016 first_err_idx  output  AW  index of the first mismatching vector; 0 if none.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on start=1 with seq_len in 1..DEPTH; latch len, idx=0, err_count=0, first_err_idx=0, pass=0, busy=1.
REQ-019 seq_len=0 with start SHALL go IDLE -> DONE directly: no stimulus, pass=1, err_count=0.
REQ-020 seq_len > DEPTH SHALL be clamped to DEPTH.
REQ-021 In RUN, a/b SHALL present mem[idx] for exactly one cycle per vector; idx increments each cycle; RUN -> DRAIN after vector len-1.
REQ-022 Outside RUN, a and b SHALL be 0.
REQ-023 Vector k driven after edge E_k SHALL be checked at edge E_k+2: {y0,y1} compared to {exp_y0,exp_y1} of vector k through a 2-stage expected-value pipeline.
REQ-024 DRAIN SHALL last 2 cycles to complete the checks still in flight, then go to DONE.
REQ-025 On mismatch, err_count increments; the first mismatch in a run latches its vector index in first_err_idx.
REQ-026 DONE SHALL last 1 cycle: done=1, busy=0 on exit, pass=(err_count==0); next state is IDLE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 load_en while busy=1 SHALL be ignored; load_en in IDLE writes on the same edge.
REQ-029 load_en and start on the same IDLE edge: the write SHALL occur and the run SHALL use the updated memory.
REQ-030 Latency start -> first a/b valid: 1 cycle; start -> done: len+3 cycles.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge from any state, including mid-run.
REQ-032 Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, pipeline cleared.
REQ-033 Vector memory SHALL NOT be affected by reset.

Configuration
REQ-034 With FSM_SEQ_STOP_ON_ERR_EN defined, the first mismatch SHALL abort RUN or DRAIN: a/b are forced to 0 and the next state is DONE with pass=0 and err_count=1.
REQ-035 Without FSM_SEQ_STOP_ON_ERR_EN, all len vectors SHALL be played and every mismatch counted.

Verification
REQ-036 Load 6 correct vectors for S0>S0>S1>S1>S0>S2>S0, seq_len=6, start -> done after 9 cycles, pass=1, err_count=0.
REQ-037 Same run with exp_y0 of vector 3 flipped -> pass=0, err_count=1, first_err_idx=3; with the macro, done arrives 2 cycles after vector 3 is driven.
REQ-038 seq_len=0, start -> done on the next cycle, pass=1, a=b=0 throughout.
REQ-039 seq_len=12 -> 8 vectors played, done 11 cycles after start; start pulsed mid-run is ignored.
REQ-040 rst=1 for 1 cycle during vector 2 -> busy=0, a=b=0 next edge; a rerun with the same memory passes.
REQ-041 load_en asserted during RUN to address 4 -> memory unchanged; the run result matches the pre-load vectors.
